// File: rtl/comparator4_checker_if.sv
// Bus between the sweep checker and its environment: start request, operands
// toward the comparator under test, its one-hot result, and the verdict.
interface comparator4_checker_if;
   logic       start;
   logic [3:0] a_out;
   logic [3:0] b_out;
   logic [2:0] c_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [3:0] fail_a;
   logic [3:0] fail_b;
   logic [2:0] fail_c;

   modport master (
      output start, c_in,
      input  a_out, b_out, busy, done, pass, err_count, fail_a, fail_b, fail_c
   );

   modport slave (
      input  start, c_in,
      output a_out, b_out, busy, done, pass, err_count, fail_a, fail_b, fail_c
   );
endinterface

// File: rtl/comparator4_checker.sv
// Exhaustive checker for a 4-bit magnitude comparator: sweeps all 256 operand
// pairs, counts mismatching results and records the first failing vector.
module comparator4_checker #(
   parameter int unsigned SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   comparator4_checker_if.slave  bus
);

   localparam int unsigned IDX_W = 8;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned ERR_W = 8;
   localparam int unsigned OP_W  = 4;
   localparam int unsigned C_W   = 3;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST    = '1;
   localparam logic [ERR_W-1:0] ERR_MAX     = '1;

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
   logic [CNT_W-1:0]  settle_q, settle_d;
   logic              start_q, start_d;
   logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
   logic [ERR_W-1:0]  err_q, err_d, err_sat;
   logic [OP_W-1:0]   fa_q, fa_d, fb_q, fb_d;
   logic [C_W-1:0]    fc_q, fc_d;
   logic              first_q, first_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [C_W-1:0]    exp_c;
   logic              mismatch;

   // Reference comparison of the operands currently presented.
   always_comb begin
      exp_c = 3'b001;
      if (a_q > b_q)       exp_c = 3'b100;
      else if (a_q == b_q) exp_c = 3'b010;
      mismatch = (bus.c_in != exp_c);
      idx_inc  = idx_q + IDX_W'(1);
      err_sat  = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      start_d  = 1'b0;
      a_d      = a_q;
      b_d      = b_q;
      err_d    = err_q;
      fa_d     = fa_q;
      fb_d     = fb_q;
      fc_d     = fc_q;
      first_d  = first_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;

      case (state_q)
         IDLE, DONE: begin
            // start is registered once, so a request launches the sweep one edge later
            if (start_q) begin
               state_d  = DRIVE;
               idx_d    = '0;
               settle_d = '0;
               a_d      = '0;
               b_d      = '0;
               err_d    = '0;
               fa_d     = '0;
               fb_d     = '0;
               fc_d     = '0;
               first_d  = 1'b0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
            end else begin
               start_d = bus.start;
            end
         end
         DRIVE: begin
            if (settle_q == SETTLE_LAST) state_d  = CHECK;
            else                         settle_d = settle_q + CNT_W'(1);
         end
         CHECK: begin
            if (mismatch) begin
               err_d = err_sat;
               if (!first_q) begin
                  first_d = 1'b1;
                  fa_d    = a_q;
                  fb_d    = b_q;
                  fc_d    = bus.c_in;
               end
            end
            if (idx_q == IDX_LAST) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = mismatch ? 1'b0 : (err_q == '0);
            end else begin
               state_d  = DRIVE;
               idx_d    = idx_inc;
               settle_d = '0;
               a_d      = idx_inc[7:4];
               b_d      = idx_inc[3:0];
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         start_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         err_q    <= '0;
         fa_q     <= '0;
         fb_q     <= '0;
         fc_q     <= '0;
         first_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         start_q  <= start_d;
         a_q      <= a_d;
         b_q      <= b_d;
         err_q    <= err_d;
         fa_q     <= fa_d;
         fb_q     <= fb_d;
         fc_q     <= fc_d;
         first_q  <= first_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign bus.a_out     = a_q;
   assign bus.b_out     = b_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_a    = fa_q;
   assign bus.fail_b    = fb_q;
   assign bus.fail_c    = fc_q;

endmodule

// File: doc/comparator4_checker.md
COMPARATOR4_CHECKER -- requirements
Module: comparator4_checker

Interface
REQ-001 Parameter: SETTLE, default 1, range 1..15; the number of cycles a vector is held before c_in is sampled.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  one-cycle request to begin a full sweep.
REQ-005 a_out  output  4  operand A driven to the comparator under test (its port a).
REQ-006 b_out  output  4  operand B driven to the comparator under test (its port b).
REQ-007 c_in  input  3  comparator result, one-hot: c[2]=a>b, c[1]=a==b, c[0]=a<b.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high after a sweep completes; held until the next accepted start or reset.
REQ-010 pass  output  1  valid while done=1; 1 when err_count==0.
REQ-011 err_count  output  8  count of mismatching vectors, saturating at 255.
REQ-012 fail_a, fail_b  output  4 each  operands of the first mismatching vector.
REQ-013 fail_c  output  3  c_in value sampled at the first mismatch.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, DRIVE, CHECK, DONE.
REQ-015 IDLE/DONE: start=1 SHALL go to DRIVE next cycle; also sets idx=0 and clears err_count, fail_*, the first-fail flag, done and pass.
REQ-016 start SHALL be ignored in DRIVE and CHECK.
REQ-017 The 8-bit vector index idx SHALL map a_out=idx[7:4], b_out=idx[3:0]; a_out/b_out are registered and change only on entering DRIVE.
REQ-018 DRIVE SHALL last exactly SETTLE cycles, timed by a 4-bit settle counter, then go to CHECK.
REQ-019 CHECK SHALL last one cycle and compare c_in with the expected code: 3'b100 if a>b, 3'b010 if a==b, 3'b001 if a<b (unsigned).
REQ-020 Any mismatch, including non-one-hot c_in such as 3'b000, 3'b110 or 3'b111, SHALL count as an error.
REQ-021 On error, err_count SHALL increment unless it is already 255; 255 holds.
REQ-022 On the first error of a sweep only, fail_a/fail_b/fail_c SHALL capture the current a_out, b_out and c_in; later errors leave them unchanged.
REQ-023 CHECK with idx<255: idx increments by 1, next state DRIVE.
REQ-024 CHECK with idx==255: next state DONE; idx does not wrap into a new sweep.
REQ-025 Sweep latency: start sampled at edge 0, done=1 after edge 1+256*(SETTLE+1).
REQ-026 busy SHALL equal 1 exactly in DRIVE and CHECK.
REQ-027 done SHALL equal 1 exactly in DONE.
REQ-028 pass SHALL be registered on entry to DONE as (final err_count==0), including an error detected in the last CHECK.
REQ-029 In IDLE and DONE, a_out/b_out SHALL hold their last driven values.
REQ-030 start asserted in the same cycle as the last CHECK SHALL be ignored; the FSM enters DONE.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, idx=0, settle counter=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_count=0, fail_a=0, fail_b=0, fail_c=0, first-fail flag cleared.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep with no retained results.
REQ-033 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-034 Correct comparator model, SETTLE=1, one start pulse: done rises 513 cycles after start, pass=1, err_count=0, fail_*=0.
REQ-035 Model stuck at c=3'b010: err_count=240, pass=0, fail_a=0, fail_b=1, fail_c=3'b010.
REQ-036 Model inverting > and < (a=1,b=0 gives 3'b001): err_count=240, first fail a=0,b=1, fail_c=3'b100.
REQ-037 Model returning 3'b000 for every vector: err_count saturates at 255, pass=0, fail_a=0, fail_b=0, fail_c=3'b000.
REQ-038 start pulsed at vector idx=0x37 mid-sweep: ignored, done timing unchanged. Separately, rst_n low for 1 cycle at idx=0x80: all outputs 0, busy=0; a new start then completes a clean sweep.
REQ-039 SETTLE=3 with a model that applies a 2-cycle delay to its result: pass=1; with SETTLE=1 the same model gives pass=0.
